// File: rtl/pipe_wb_queue_pkg.sv
// Shared definitions for the write-back commit queue: exception codes,
// the exception-source-to-code table and the per-entry control struct.
package pipe_wb_queue_pkg;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0b;
  localparam logic [5:0] ECODE_BRK  = 6'h0c;
  localparam logic [5:0] ECODE_INE  = 6'h0d;
  localparam logic [5:0] ECODE_TLBR = 6'h3f;

  localparam logic [8:0] ESUBCODE_NONE = 9'd0;
  localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
  localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

  typedef struct packed {
    logic [5:0] ecode;
    logic [8:0] esubcode;
  } exc_code_t;

  // Control portion of a queued entry; the DATA_W-wide fields (pc, rf data,
  // vaddr) and the exception vector are packed alongside it by the top.
  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic        ertn;
    logic        refetch;
  } wb_ctrl_t;

  localparam int CTRL_W = $bits(wb_ctrl_t);

  // Exception source index to (ecode, esubcode); lower index wins upstream.
  function automatic exc_code_t exc_code_lookup(input int idx);
    exc_code_t c;
    case (idx)
      0:       c = '{ecode: ECODE_INT,  esubcode: ESUBCODE_NONE};
      1:       c = '{ecode: ECODE_ADE,  esubcode: ESUBCODE_ADEF};
      2:       c = '{ecode: ECODE_TLBR, esubcode: ESUBCODE_NONE};
      3:       c = '{ecode: ECODE_PIF,  esubcode: ESUBCODE_NONE};
      4:       c = '{ecode: ECODE_PPI,  esubcode: ESUBCODE_NONE};
      5:       c = '{ecode: ECODE_ADE,  esubcode: ESUBCODE_ADEM};
      6:       c = '{ecode: ECODE_ALE,  esubcode: ESUBCODE_NONE};
      7:       c = '{ecode: ECODE_SYS,  esubcode: ESUBCODE_NONE};
      8:       c = '{ecode: ECODE_BRK,  esubcode: ESUBCODE_NONE};
      default: c = '{ecode: ECODE_INE,  esubcode: ESUBCODE_NONE};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_wb_queue_wb_fifo.sv
// Circular FIFO storage for the commit queue. Pointers wrap modulo DEPTH;
// a flush empties the queue and overrides any same-cycle push or pop.
module wb_fifo
  import pipe_wb_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       head_valid,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next-state pointers, count and valid bits; pop retires before push fills.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
    end else begin
      if (pop) begin
        valid_d[head_q] = 1'b0;
        head_d          = next_ptr(head_q);
      end
      if (push) begin
        valid_d[tail_q] = 1'b1;
        tail_d          = next_ptr(tail_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage is never reset; valid bits and count guard its use.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[tail_q] <= wdata;
    end
  end

  assign rdata      = mem_q[head_q];
  assign head_valid = valid_q[head_q];
  assign occupancy  = count_q;

endmodule

// File: rtl/pipe_wb_queue.sv
// Write-back commit queue: buffers MEM-stage results and retires one head
// entry per cycle, turning exceptions, ERTN and refetch into queue flushes.
module pipe_wb_queue
  import pipe_wb_queue_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int EXC_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   from_valid,
  output logic                   to_allowin,
  input  logic [DATA_W-1:0]      from_pc,
  input  logic                   rf_we_MEM,
  input  logic [4:0]             rf_waddr_MEM,
  input  logic [DATA_W-1:0]      rf_wdata_MEM,
  input  logic                   csr_we_MEM,
  input  logic [13:0]            csr_num_MEM,
  input  logic [31:0]            csr_wmask_MEM,
  input  logic [31:0]            csr_wdata_MEM,
  input  logic                   ertn_MEM,
  input  logic                   refetch_MEM,
  input  logic [EXC_W-1:0]       exc_MEM,
  input  logic [DATA_W-1:0]      vaddr_MEM,
  input  logic                   commit_stall,
  output logic                   rf_we,
  output logic [4:0]             rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic                   csr_we_out,
  output logic [13:0]            csr_num,
  output logic [31:0]            csr_wmask,
  output logic [31:0]            csr_wdata,
  output logic                   ertn_flush_out,
  output logic                   refetch_flush_out,
  output logic                   wb_ex,
  output logic [5:0]             wb_ecode,
  output logic [8:0]             wb_esubcode,
  output logic [DATA_W-1:0]      wb_vaddr,
  output logic [DATA_W-1:0]      wb_pc,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int PAY_W = CTRL_W + EXC_W + 3 * DATA_W;

  wb_ctrl_t          in_ctrl;
  wb_ctrl_t          head_ctrl;
  logic [EXC_W-1:0]  head_exc;
  logic [DATA_W-1:0] head_pc;
  logic [DATA_W-1:0] head_wdata;
  logic [DATA_W-1:0] head_vaddr;
  logic [PAY_W-1:0]  push_payload;
  logic [PAY_W-1:0]  head_payload;
  logic              head_valid;
  logic              commit;
  logic              push;
  logic              flush;
  logic              head_has_exc;
  int                exc_idx;
  exc_code_t         exc_code;

  assign in_ctrl = '{
    rf_we:     rf_we_MEM,
    rf_waddr:  rf_waddr_MEM,
    csr_we:    csr_we_MEM,
    csr_num:   csr_num_MEM,
    csr_wmask: csr_wmask_MEM,
    csr_wdata: csr_wdata_MEM,
    ertn:      ertn_MEM,
    refetch:   refetch_MEM
  };

  assign push_payload = {vaddr_MEM, from_pc, rf_wdata_MEM, exc_MEM, in_ctrl};
  assign {head_vaddr, head_pc, head_wdata, head_exc, head_ctrl} = head_payload;

  assign head_has_exc = |head_exc;
  assign commit       = (occupancy != '0) && head_valid && !commit_stall;
  assign to_allowin   = (occupancy < OCC_W'(DEPTH)) || commit;
  assign push         = from_valid && to_allowin;
  assign flush        = commit && (head_has_exc || head_ctrl.ertn || head_ctrl.refetch);

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAY_W)
  ) u_wb_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (commit),
    .flush      (flush),
    .wdata      (push_payload),
    .rdata      (head_payload),
    .head_valid (head_valid),
    .occupancy  (occupancy)
  );

  // Pick the lowest set exception source of the head entry and map it to a code.
  always_comb begin
    exc_idx = 0;
    for (int i = EXC_W - 1; i >= 0; i--) begin
      if (head_exc[i]) exc_idx = i;
    end
    exc_code = exc_code_lookup(exc_idx);
  end

  // Commit-qualified outputs; an exception masks all writes and other flushes.
  always_comb begin
    rf_we             = 1'b0;
    rf_waddr          = '0;
    rf_wdata          = '0;
    csr_we_out        = 1'b0;
    csr_num           = '0;
    csr_wmask         = '0;
    csr_wdata         = '0;
    ertn_flush_out    = 1'b0;
    refetch_flush_out = 1'b0;
    wb_ex             = 1'b0;
    wb_ecode          = '0;
    wb_esubcode       = '0;
    wb_pc             = (occupancy != '0) ? head_pc : '0;
    wb_vaddr          = (occupancy != '0) ? head_vaddr : '0;
    if (commit) begin
      if (head_has_exc) begin
        wb_ex       = 1'b1;
        wb_ecode    = exc_code.ecode;
        wb_esubcode = exc_code.esubcode;
      end else begin
        rf_we = head_ctrl.rf_we;
        if (head_ctrl.rf_we) begin
          rf_waddr = head_ctrl.rf_waddr;
          rf_wdata = head_wdata;
        end
        csr_we_out = head_ctrl.csr_we;
        if (head_ctrl.csr_we) begin
          csr_num   = head_ctrl.csr_num;
          csr_wmask = head_ctrl.csr_wmask;
          csr_wdata = head_ctrl.csr_wdata;
        end
        ertn_flush_out    = head_ctrl.ertn;
        refetch_flush_out = head_ctrl.refetch && !head_ctrl.ertn;
      end
    end
  end

endmodule

// File: tb/tb_pipe_wb_queue.sv
// Scoreboard bench for pipe_wb_queue: a DEPTH=2 and a DEPTH=4 instance share
// stimulus, directed checks probe occupancy/flags, a monitor checks commits.
module tb_pipe_wb_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [31:0] wdata;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic        ertn;
    logic        refetch;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] vaddr;
  } rec_t;

  logic        clk;
  logic        reset;
  logic        from_valid, sel2, sel4;
  logic [31:0] from_pc, rf_wdata_MEM, csr_wdata_MEM, csr_wmask_MEM, vaddr_MEM;
  logic        rf_we_MEM, csr_we_MEM, ertn_MEM, refetch_MEM, commit_stall;
  logic [4:0]  rf_waddr_MEM;
  logic [13:0] csr_num_MEM;
  logic [7:0]  exc_MEM;

  logic        allow_2, rf_we_2, csr_we_2, ertn_2, refetch_2, wb_ex_2;
  logic [4:0]  rf_waddr_2;
  logic [31:0] rf_wdata_2, csr_wmask_2, csr_wdata_2, wb_vaddr_2, wb_pc_2;
  logic [13:0] csr_num_2;
  logic [5:0]  ecode_2;
  logic [8:0]  esub_2;
  logic [1:0]  occ_2;

  logic        allow_4, rf_we_4, csr_we_4, ertn_4, refetch_4, wb_ex_4;
  logic [4:0]  rf_waddr_4;
  logic [31:0] rf_wdata_4, csr_wmask_4, csr_wdata_4, wb_vaddr_4, wb_pc_4;
  logic [13:0] csr_num_4;
  logic [5:0]  ecode_4;
  logic [8:0]  esub_4;
  logic [2:0]  occ_4;

  rec_t exp2[$];
  rec_t exp4[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  assign rf_waddr_MEM = from_pc[6:2];
  assign vaddr_MEM    = from_pc ^ 32'hffff_0000;

  pipe_wb_queue #(.DEPTH(2), .EXC_W(8), .DATA_W(32)) u_dut2 (
    .clk(clk), .reset(reset), .from_valid(from_valid && sel2), .to_allowin(allow_2),
    .from_pc(from_pc), .rf_we_MEM(rf_we_MEM), .rf_waddr_MEM(rf_waddr_MEM),
    .rf_wdata_MEM(rf_wdata_MEM), .csr_we_MEM(csr_we_MEM), .csr_num_MEM(csr_num_MEM),
    .csr_wmask_MEM(csr_wmask_MEM), .csr_wdata_MEM(csr_wdata_MEM), .ertn_MEM(ertn_MEM),
    .refetch_MEM(refetch_MEM), .exc_MEM(exc_MEM), .vaddr_MEM(vaddr_MEM),
    .commit_stall(commit_stall), .rf_we(rf_we_2), .rf_waddr(rf_waddr_2),
    .rf_wdata(rf_wdata_2), .csr_we_out(csr_we_2), .csr_num(csr_num_2),
    .csr_wmask(csr_wmask_2), .csr_wdata(csr_wdata_2), .ertn_flush_out(ertn_2),
    .refetch_flush_out(refetch_2), .wb_ex(wb_ex_2), .wb_ecode(ecode_2),
    .wb_esubcode(esub_2), .wb_vaddr(wb_vaddr_2), .wb_pc(wb_pc_2), .occupancy(occ_2)
  );

  pipe_wb_queue #(.DEPTH(4), .EXC_W(8), .DATA_W(32)) u_dut4 (
    .clk(clk), .reset(reset), .from_valid(from_valid && sel4), .to_allowin(allow_4),
    .from_pc(from_pc), .rf_we_MEM(rf_we_MEM), .rf_waddr_MEM(rf_waddr_MEM),
    .rf_wdata_MEM(rf_wdata_MEM), .csr_we_MEM(csr_we_MEM), .csr_num_MEM(csr_num_MEM),
    .csr_wmask_MEM(csr_wmask_MEM), .csr_wdata_MEM(csr_wdata_MEM), .ertn_MEM(ertn_MEM),
    .refetch_MEM(refetch_MEM), .exc_MEM(exc_MEM), .vaddr_MEM(vaddr_MEM),
    .commit_stall(commit_stall), .rf_we(rf_we_4), .rf_waddr(rf_waddr_4),
    .rf_wdata(rf_wdata_4), .csr_we_out(csr_we_4), .csr_num(csr_num_4),
    .csr_wmask(csr_wmask_4), .csr_wdata(csr_wdata_4), .ertn_flush_out(ertn_4),
    .refetch_flush_out(refetch_4), .wb_ex(wb_ex_4), .wb_ecode(ecode_4),
    .wb_esubcode(esub_4), .wb_vaddr(wb_vaddr_4), .wb_pc(wb_pc_4), .occupancy(occ_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t mk(input logic [31:0] pc, input logic we, input logic [31:0] wd,
                              input logic ex, input logic [5:0] ec, input logic [8:0] es,
                              input logic er, input logic rf, input logic cw,
                              input logic [31:0] cd);
    rec_t r;
    r = '{pc: pc, rf_we: we, wdata: wd, ex: ex, ecode: ec, esub: es, ertn: er,
          refetch: rf, csr_we: cw, csr_wdata: cd, vaddr: pc ^ 32'hffff_0000};
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check_rec(input string name, input rec_t obs, input bit have, input rec_t e);
    checks_total++;
    if (!have)
      $display("[TB] FAIL %s: unexpected commit pc=0x%08h, expected no commit", name, obs.pc);
    else if (obs === e)
      checks_passed++;
    else
      $display("[TB] FAIL %s: got pc=%h we=%b wd=%h ex=%b ec=%h es=%h er=%b rf=%b cw=%b cd=%h va=%h, expected pc=%h we=%b wd=%h ex=%b ec=%h es=%h er=%b rf=%b cw=%b cd=%h va=%h",
               name, obs.pc, obs.rf_we, obs.wdata, obs.ex, obs.ecode, obs.esub, obs.ertn,
               obs.refetch, obs.csr_we, obs.csr_wdata, obs.vaddr, e.pc, e.rf_we, e.wdata,
               e.ex, e.ecode, e.esub, e.ertn, e.refetch, e.csr_we, e.csr_wdata, e.vaddr);
  endtask

  // Commit monitor: any visible commit event pops and compares the scoreboard.
  always @(negedge clk) begin
    rec_t obs;
    rec_t e;
    bit   have;
    if (reset) begin
      if (rf_we_2 || wb_ex_2 || ertn_2 || refetch_2) begin
        obs  = {wb_pc_2, rf_we_2, rf_wdata_2, wb_ex_2, ecode_2, esub_2, ertn_2, refetch_2,
                csr_we_2, csr_wdata_2, wb_vaddr_2};
        have = (exp2.size() != 0);
        e    = have ? exp2.pop_front() : '0;
        check_rec("commit_d2", obs, have, e);
      end
      if (rf_we_4 || wb_ex_4 || ertn_4 || refetch_4) begin
        obs  = {wb_pc_4, rf_we_4, rf_wdata_4, wb_ex_4, ecode_4, esub_4, ertn_4, refetch_4,
                csr_we_4, csr_wdata_4, wb_vaddr_4};
        have = (exp4.size() != 0);
        e    = have ? exp4.pop_front() : '0;
        check_rec("commit_d4", obs, have, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] pc, input logic [31:0] wd,
                                input logic [7:0] exc, input logic er, input logic rf,
                                input logic st);
    from_valid   = v;
    from_pc      = pc;
    rf_we_MEM    = 1'b1;
    rf_wdata_MEM = wd;
    exc_MEM      = exc;
    ertn_MEM     = er;
    refetch_MEM  = rf;
    commit_stall = st;
  endtask

  initial begin
    reset = 1'b0; sel2 = 1'b1; sel4 = 1'b0;
    csr_we_MEM = 1'b0; csr_num_MEM = '0; csr_wmask_MEM = '0; csr_wdata_MEM = '0;
    apply_stimulus(0, 32'h0, 32'h0, 8'h0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #3;
    check_output("reset_occ", 32'(occ_2), 32'd0);
    check_output("reset_allowin", 32'(allow_2), 32'd1);
    check_output("reset_wb_pc", wb_pc_2, 32'd0);
    reset = 1'b1;

    // Fill DEPTH=2 under stall, then push and commit together at full
    step(); apply_stimulus(1, 32'h1c00_0000, 32'h11, 8'h0, 0, 0, 1);
    #2 check_output("fill_allowin0", 32'(allow_2), 32'd1);
    step(); apply_stimulus(1, 32'h1c00_0004, 32'h22, 8'h0, 0, 0, 1);
    #2 check_output("fill_occ1", 32'(occ_2), 32'd1);
    step(); apply_stimulus(1, 32'h1c00_0008, 32'h33, 8'h0, 0, 0, 1);
    #2 check_output("full_allowin", 32'(allow_2), 32'd0);
    check_output("full_occ", 32'(occ_2), 32'd2);
    exp2.push_back(mk(32'h1c00_0000, 1, 32'h11, 0, 6'h0, 9'h0, 0, 0, 0, 32'h0));
    exp2.push_back(mk(32'h1c00_0004, 1, 32'h22, 0, 6'h0, 9'h0, 0, 0, 0, 32'h0));
    exp2.push_back(mk(32'h1c00_0008, 1, 32'h33, 0, 6'h0, 9'h0, 0, 0, 0, 32'h0));
    step(); apply_stimulus(1, 32'h1c00_0008, 32'h33, 8'h0, 0, 0, 0);
    #2 check_output("full_commit_allowin", 32'(allow_2), 32'd1);
    step(); apply_stimulus(0, 32'h0, 32'h0, 8'h0, 0, 0, 0);
    #2 check_output("pushpop_occ", 32'(occ_2), 32'd2);
    step(); #2 check_output("drain_occ1", 32'(occ_2), 32'd1);
    step(); #2 check_output("drain_occ0", 32'(occ_2), 32'd0);

    // Exception at head: writes masked, younger and same-cycle push dropped
    step(); apply_stimulus(1, 32'h1c00_0100, 32'h44, 8'b0000_0110, 0, 0, 1);
    step(); apply_stimulus(1, 32'h1c00_0104, 32'h55, 8'h0, 0, 0, 1);
    exp2.push_back(mk(32'h1c00_0100, 0, 32'h0, 1, 6'h08, 9'h0, 0, 0, 0, 32'h0));
    step(); apply_stimulus(1, 32'h1c00_0108, 32'h99, 8'h0, 0, 0, 0);
    #2 check_output("exc_wb_ex", 32'(wb_ex_2), 32'd1);
    check_output("exc_ecode", 32'(ecode_2), 32'h08);
    check_output("exc_rf_we", 32'(rf_we_2), 32'd0);
    check_output("exc_occ_before", 32'(occ_2), 32'd2);
    step(); apply_stimulus(0, 32'h0, 32'h0, 8'h0, 0, 0, 0);
    #2 check_output("exc_occ_after", 32'(occ_2), 32'd0);

    // Single exception with a non-zero subcode
    step(); apply_stimulus(1, 32'h1c00_0110, 32'haa, 8'b0010_0000, 0, 0, 0);
    exp2.push_back(mk(32'h1c00_0110, 0, 32'h0, 1, 6'h08, 9'h1, 0, 0, 0, 32'h0));
    #2 check_output("latency_no_bypass", 32'(wb_ex_2), 32'd0);
    step(); apply_stimulus(0, 32'h0, 32'h0, 8'h0, 0, 0, 0);
    #2 check_output("adem_esub", 32'(esub_2), 32'd1);
    step(); #2 check_output("adem_occ", 32'(occ_2), 32'd0);

    // ERTN beats refetch; younger 0x1c000008 must never commit
    step(); apply_stimulus(1, 32'h1c00_0004, 32'h66, 8'h0, 1, 1, 1);
    step(); apply_stimulus(1, 32'h1c00_0008, 32'h77, 8'h0, 0, 0, 1);
    exp2.push_back(mk(32'h1c00_0004, 1, 32'h66, 0, 6'h0, 9'h0, 1, 0, 0, 32'h0));
    step(); apply_stimulus(0, 32'h0, 32'h0, 8'h0, 0, 0, 0);
    #2 check_output("ertn_flush", 32'(ertn_2), 32'd1);
    check_output("ertn_refetch", 32'(refetch_2), 32'd0);
    step(); #2 check_output("ertn_occ", 32'(occ_2), 32'd0);
    step();

    // Refetch with a CSR write on the head entry
    csr_we_MEM = 1'b1; csr_num_MEM = 14'h10; csr_wmask_MEM = 32'hffff_ffff;
    csr_wdata_MEM = 32'h0000_abcd;
    apply_stimulus(1, 32'h1c00_0200, 32'h88, 8'h0, 0, 1, 1);
    step(); csr_we_MEM = 1'b0;
    apply_stimulus(1, 32'h1c00_0204, 32'h89, 8'h0, 0, 0, 1);
    exp2.push_back(mk(32'h1c00_0200, 1, 32'h88, 0, 6'h0, 9'h0, 0, 1, 1, 32'h0000_abcd));
    step(); apply_stimulus(0, 32'h0, 32'h0, 8'h0, 0, 0, 0);
    #2 check_output("refetch_flush", 32'(refetch_2), 32'd1);
    check_output("refetch_csr_num", 32'(csr_num_2), 32'h10);
    step(); #2 check_output("refetch_occ", 32'(occ_2), 32'd0);

    // Reset mid-operation with two queued entries
    step(); apply_stimulus(1, 32'h1c00_0300, 32'h12, 8'h0, 0, 0, 1);
    step(); apply_stimulus(1, 32'h1c00_0304, 32'h13, 8'h0, 0, 0, 1);
    step(); apply_stimulus(0, 32'h0, 32'h0, 8'h0, 0, 0, 1);
    #2 check_output("prereset_occ", 32'(occ_2), 32'd2);
    reset = 1'b0;
    #1 check_output("midreset_occ", 32'(occ_2), 32'd0);
    check_output("midreset_allowin", 32'(allow_2), 32'd1);
    check_output("midreset_wb_pc", wb_pc_2, 32'd0);
    step(); reset = 1'b1; apply_stimulus(0, 32'h0, 32'h0, 8'h0, 0, 0, 0);
    #2 check_output("postreset_rf_we", 32'(rf_we_2), 32'd0);
    step(); #2 check_output("postreset_occ", 32'(occ_2), 32'd0);

    // DEPTH=4 pointer wrap: 20 entries streamed through the queue
    sel2 = 1'b0; sel4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      apply_stimulus(1, 32'h1c00_1000 + 32'(4 * i), 32'(i + 1), 8'h0, 0, 0, (i < 2) ? 1'b1 : 1'b0);
      exp4.push_back(mk(32'h1c00_1000 + 32'(4 * i), 1, 32'(i + 1), 0, 6'h0, 9'h0, 0, 0, 0, 32'h0));
    end
    step(); apply_stimulus(0, 32'h0, 32'h0, 8'h0, 0, 0, 0);
    #2 check_output("wrap_occ2", 32'(occ_4), 32'd2);
    step(); #2 check_output("wrap_occ1", 32'(occ_4), 32'd1);
    step(); #2 check_output("wrap_occ0", 32'(occ_4), 32'd0);
    step();
    check_output("sb2_empty", 32'(exp2.size()), 32'd0);
    check_output("sb4_empty", 32'(exp4.size()), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/pipe_wb_queue.md
PIPE_WB_QUEUE -- requirements
Module: pipe_wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning queue entries; legal values are 2, 4, 8.
REQ-002 SHALL have parameter EXC_W, default 8, meaning number of exception-source bits; index 0 has the highest priority.
REQ-003 SHALL have parameter DATA_W, default 32, meaning PC, data and vaddr width.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 from_valid  in  1  the upstream (MEM) entry is valid.
REQ-007 to_allowin  out  1  the queue accepts an entry this cycle.
REQ-008 from_pc  in  DATA_W  PC of the entry.
REQ-009 rf_we_MEM / rf_waddr_MEM / rf_wdata_MEM  in  1/5/DATA_W  GPR write request.
REQ-010 csr_we_MEM / csr_num_MEM / csr_wmask_MEM / csr_wdata_MEM  in  1/14/32/32  CSR write request.
REQ-011 ertn_MEM, refetch_MEM  in  1 each  ERTN flag; refetch flag (TLB/CSR side effect).
REQ-012 exc_MEM  in  EXC_W  one-hot-or-more exception sources.
REQ-013 vaddr_MEM  in  DATA_W  bad virtual address.
REQ-014 commit_stall  in  1  inhibits commit this cycle.
REQ-015 rf_we, rf_waddr, rf_wdata  out  1/5/DATA_W  GPR write port.
REQ-016 csr_we_out, csr_num, csr_wmask, csr_wdata  out  1/14/32/32  CSR write port.
REQ-017 ertn_flush_out, refetch_flush_out, wb_ex  out  1 each  commit-time flush events.
REQ-018 wb_ecode, wb_esubcode, wb_vaddr, wb_pc  out  6/9/DATA_W/DATA_W  exception info and committed PC.
REQ-019 occupancy  out  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-020 SHALL store entries in a circular FIFO with head/tail pointers that wrap modulo DEPTH.
REQ-021 SHALL accept an entry (push) when from_valid && to_allowin.
REQ-022 SHALL drive to_allowin = (occupancy < DEPTH) || commit, so that a simultaneous push and pop at full is legal.
REQ-023 SHALL define commit = (occupancy != 0) && !commit_stall; exactly one head entry retires per commit cycle.
REQ-024 SHALL make a pushed entry committable no earlier than the cycle after its push (1-cycle minimum latency); no bypass.
REQ-025 SHALL qualify every write/event output with commit; all are 0 when not committing.
REQ-026 SHALL set wb_ex = commit && (head exc != 0).
REQ-027 SHALL take wb_ecode/wb_esubcode from the lowest set exc index via the package table.
REQ-028 SHALL suppress rf_we, csr_we_out, ertn_flush_out and refetch_flush_out when wb_ex is asserted.
REQ-029 SHALL give precedence wb_ex > ertn > refetch when more than one is set.
REQ-030 SHALL, on a commit with wb_ex, ertn or refetch, empty the queue at that edge: drop all younger entries and any same-cycle push; occupancy becomes 0.
REQ-031 SHALL drive wb_pc and wb_vaddr from the head whenever occupancy != 0, and 0 otherwise.
REQ-032 SHALL keep occupancy exact: +1 on push, -1 on commit, unchanged on both, 0 on flush.

Reset
REQ-033 SHALL, while reset is low, clear pointers, occupancy and all entry valid bits asynchronously; payload registers need not be reset.
REQ-034 SHALL hold every output at 0 during reset, with to_allowin = 1 once occupancy = 0.
REQ-035 SHALL discard any queued entries if reset asserts mid-operation; nothing commits in the first cycle after release.

Structure
REQ-036 SHALL place ECODE/ESUBCODE constants, the EXC_W index-to-code table and the entry struct typedef in the shared define package.
REQ-037 SHALL implement storage as one sub-module, wb_fifo (DEPTH, payload width parameters), with the commit/exception logic in pipe_wb_queue.

Verification
REQ-038 Push 3 entries back-to-back with DEPTH=2 and commit_stall=1 -> to_allowin=0 on the 3rd cycle, occupancy=2.
REQ-039 At full, push and commit in the same cycle -> occupancy stays 2, FIFO order preserved, rf_wdata sequence 0x11, 0x22, 0x33.
REQ-040 Head has exc=8'b0000_0110 with rf_we=1 -> wb_ex=1, ecode of index 1, rf_we=0, occupancy 2->0, same-cycle push dropped.
REQ-041 Head has ertn=1, refetch=1 -> ertn_flush_out=1, refetch_flush_out=0, younger entry PC 0x1c000008 never committed.
REQ-042 Reset low for 1 cycle with occupancy 2 -> outputs immediately 0, occupancy=0, no commit on the cycle after release.
REQ-043 Pointer wrap with DEPTH=4 over 20 push/commit pairs -> all 20 PCs committed in order, none lost or duplicated.
